// File: rtl/waterbear_mem_arbiter_pkg.sv
// Shared types for the waterbear RAM arbiter: requester ids, FSM states and
// the round-robin pointer helpers.
package waterbear_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        REQ_HOST  = 2'd0,
        REQ_FETCH = 2'd1,
        REQ_DATA  = 2'd2
    } req_id_t;

    typedef enum logic [1:0] {
        ARB_RUN   = 2'd0,
        ARB_DRAIN = 2'd1,
        ARB_HOLD  = 2'd2
    } arb_state_t;

    // Requester after the winner; DATA wraps back to HOST.
    function automatic req_id_t rr_next(input req_id_t id);
        case (id)
            REQ_HOST:  return REQ_FETCH;
            REQ_FETCH: return REQ_DATA;
            default:   return REQ_HOST;
        endcase
    endfunction

    // Grant vector bit order is {data, fetch, host}.
    function automatic req_id_t onehot_to_id(input logic [2:0] oh);
        if (oh[2])      return REQ_DATA;
        else if (oh[1]) return REQ_FETCH;
        else            return REQ_HOST;
    endfunction

endpackage

// File: rtl/waterbear_mem_arbiter_if.sv
// Requester, host-control and RAM-side signals of the waterbear arbiter.
// slave = arbiter side, master = requesters plus RAM macro.
interface waterbear_mem_arbiter_if
    import waterbear_pkg::*;
#(
    parameter int AW = ADDR_W,
    parameter int DW = DATA_W
);
    logic          host_hold;
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          f_gnt;
    logic          f_rvalid;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic          h_req;
    logic          h_we;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_wdata;
    logic          h_gnt;
    logic          h_rvalid;
    logic [DW-1:0] rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    modport slave (
        input  host_hold, f_req, f_addr, d_req, d_we, d_addr, d_wdata,
               h_req, h_we, h_addr, h_wdata, mem_rdata,
        output f_gnt, f_rvalid, d_gnt, d_rvalid, h_gnt, h_rvalid, rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output host_hold, f_req, f_addr, d_req, d_we, d_addr, d_wdata,
               h_req, h_we, h_addr, h_wdata, mem_rdata,
        input  f_gnt, f_rvalid, d_gnt, d_rvalid, h_gnt, h_rvalid, rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );

endinterface

// File: rtl/waterbear_mem_arbiter_rr_pick.sv
// 3-way rotating-priority picker: search starts at ptr_i, first requester wins.
// Bit order of req_i/gnt_o is {data, fetch, host}.
module waterbear_rr_pick
    import waterbear_pkg::*;
(
    input  logic [2:0] req_i,
    input  req_id_t    ptr_i,
    output logic [2:0] gnt_o
);

    always_comb begin
        gnt_o = 3'b000;
        case (ptr_i)
            REQ_FETCH: begin
                if (req_i[1])      gnt_o[1] = 1'b1;
                else if (req_i[2]) gnt_o[2] = 1'b1;
                else if (req_i[0]) gnt_o[0] = 1'b1;
            end
            REQ_DATA: begin
                if (req_i[2])      gnt_o[2] = 1'b1;
                else if (req_i[0]) gnt_o[0] = 1'b1;
                else if (req_i[1]) gnt_o[1] = 1'b1;
            end
            default: begin
                if (req_i[0])      gnt_o[0] = 1'b1;
                else if (req_i[1]) gnt_o[1] = 1'b1;
                else if (req_i[2]) gnt_o[2] = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/waterbear_mem_arbiter.sv
// Round-robin arbiter sharing the single-port program/data RAM between CPU
// fetch, CPU data and the host port, with a host hold mode for programming.
module waterbear_mem_arbiter
    import waterbear_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    waterbear_mem_arbiter_if.slave bus
);

    arb_state_t        state_q, state_d;
    req_id_t           rr_ptr_q, rr_ptr_d;
    logic              pend_vld_q, pend_vld_d;
    req_id_t           pend_id_q, pend_id_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [2:0]        req_all, req_mask, gnt;
    req_id_t           win_id;
    logic              cpu_pend;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    assign req_all  = {bus.d_req, bus.f_req, bus.h_req};
    assign cpu_pend = pend_vld_q && (pend_id_q != REQ_HOST);

    // Which requesters may compete this cycle; reset masks everything so the
    // combinational grants drop as soon as rst_n falls.
    always_comb begin
        state_d  = state_q;
        req_mask = 3'b000;
        case (state_q)
            ARB_RUN: begin
                if (bus.host_hold) begin
                    req_mask = 3'b001;
                    state_d  = cpu_pend ? ARB_DRAIN : ARB_HOLD;
                end else begin
                    req_mask = 3'b111;
                end
            end
            ARB_DRAIN: state_d = ARB_HOLD;
            ARB_HOLD: begin
                req_mask = 3'b001;
                if (!bus.host_hold) state_d = ARB_RUN;
            end
            default: state_d = ARB_RUN;
        endcase
        if (!rst_n) req_mask = 3'b000;
    end

    waterbear_rr_pick u_pick (
        .req_i (req_all & req_mask),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt)
    );

    assign win_id = onehot_to_id(gnt);

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (state_q == ARB_HOLD && !bus.host_hold) rr_ptr_d = REQ_FETCH;
        else if (|gnt)                             rr_ptr_d = rr_next(win_id);
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt[0]) begin
            mem_we    = bus.h_we;
            mem_addr  = bus.h_addr;
            mem_wdata = bus.h_wdata;
        end else if (gnt[1]) begin
            mem_addr  = bus.f_addr;
        end else if (gnt[2]) begin
            mem_we    = bus.d_we;
            mem_addr  = bus.d_addr;
            mem_wdata = bus.d_wdata;
        end
    end

    // A granted read returns next cycle to whoever owned it.
    assign pend_vld_d = (|gnt) && !mem_we;
    assign pend_id_d  = win_id;
    assign rdata_d    = pend_vld_q ? bus.mem_rdata : rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB_RUN;
            rr_ptr_q   <= REQ_HOST;
            pend_vld_q <= 1'b0;
            pend_id_q  <= REQ_HOST;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            pend_vld_q <= pend_vld_d;
            pend_id_q  <= pend_id_d;
            rdata_q    <= rdata_d;
        end
    end

    assign bus.h_gnt     = gnt[0];
    assign bus.f_gnt     = gnt[1];
    assign bus.d_gnt     = gnt[2];
    assign bus.h_rvalid  = pend_vld_q && (pend_id_q == REQ_HOST);
    assign bus.f_rvalid  = pend_vld_q && (pend_id_q == REQ_FETCH);
    assign bus.d_rvalid  = pend_vld_q && (pend_id_q == REQ_DATA);
    assign bus.rdata     = rdata_d;
    assign bus.mem_en    = |gnt;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.busy      = (state_q != ARB_RUN);

endmodule
